carfield_periph_apb_xbar: RTL and testbench

Single-requester APB demultiplexer for the Carfield peripheral window (0x2000_1000–0x2000_9FFF). It sits directly downstream of the host-side AXI-to-APB bridge and fans accesses out to the CAN, system timer, advanced timer, watchdog and HyperBus-config completers. Unmapped or disabled addresses return a decode error. A per-access timeout counter aborts hung completers and reports them.

---
 rtl/carfield_periph_pkg.sv | 57 +++++
 rtl/carfield_periph_addr_decode.sv | 38 +++
 rtl/carfield_periph_apb_xbar.sv | 197 +++++++++++++++++++
 tb/tb_carfield_periph_apb_xbar.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_periph_pkg.sv
// Shared types and address map for the Carfield peripheral APB crossbar.
// Region bases, rule records and FSM encoding live here.
package carfield_periph_pkg;

    localparam int unsigned NumPeriphPorts = 5;
    localparam int unsigned PortIdxW       = 3;

    localparam logic [31:0] PeriphRegionSize = 32'h0000_1000;
    localparam logic [31:0] CanBase          = 32'h2000_1000;
    localparam logic [31:0] SysTimerBase     = 32'h2000_4000;
    localparam logic [31:0] AdvTimerBase     = 32'h2000_5000;
    localparam logic [31:0] WatchdogBase     = 32'h2000_7000;
    localparam logic [31:0] HyperBusBase     = 32'h2000_9000;

    localparam logic [31:0] ErrDataDefault = 32'hBADC_AB1E;

    typedef enum logic [PortIdxW-1:0] {
        PortCan      = 3'd0,
        PortSysTimer = 3'd1,
        PortAdvTimer = 3'd2,
        PortWatchdog = 3'd3,
        PortHyperBus = 3'd4
    } periph_port_e;

    typedef struct packed {
        periph_port_e idx;
        logic [31:0]  start_addr;
        logic [31:0]  end_addr;
    } addr_rule_t;

    typedef addr_rule_t [NumPeriphPorts-1:0] addr_map_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } xbar_state_e;

    // End address is exclusive: base <= addr < base + size.
    function automatic addr_rule_t mk_rule(periph_port_e p, logic [31:0] base);
        addr_rule_t r;
        r.idx        = p;
        r.start_addr = base;
        r.end_addr   = base + PeriphRegionSize;
        return r;
    endfunction

    localparam addr_map_t DefaultAddrMap = '{
        mk_rule(PortHyperBus, HyperBusBase),
        mk_rule(PortWatchdog, WatchdogBase),
        mk_rule(PortAdvTimer, AdvTimerBase),
        mk_rule(PortSysTimer, SysTimerBase),
        mk_rule(PortCan,      CanBase)
    };

endpackage

// File: rtl/carfield_periph_addr_decode.sv
// Combinational first-match address decoder over the peripheral rule map.
// The CAN rule can be masked out so its window decodes as an error.
module carfield_periph_addr_decode
    import carfield_periph_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned NumRules  = NumPeriphPorts,
    parameter bit          CanEnable = 1'b1
) (
    input  logic [AddrWidth-1:0]      addr_i,
    input  addr_rule_t [NumRules-1:0] rules_i,
    output logic [PortIdxW-1:0]       idx_o,
    output logic                      hit_o
);

    logic                 found;
    logic [PortIdxW-1:0]  idx;
    logic                 rule_on;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        rule_on = 1'b0;
        for (int i = 0; i < int'(NumRules); i++) begin
            rule_on = CanEnable || (rules_i[i].idx != PortCan);
            if (!found && rule_on &&
                addr_i >= AddrWidth'(rules_i[i].start_addr) &&
                addr_i <  AddrWidth'(rules_i[i].end_addr)) begin
                found = 1'b1;
                idx   = rules_i[i].idx;
            end
        end
    end

    assign idx_o = idx;
    assign hit_o = found;

endmodule

// File: rtl/carfield_periph_apb_xbar.sv
// Single-requester APB demux for the Carfield peripheral window with
// decode-error responses and a per-access timeout on hung completers.
module carfield_periph_apb_xbar
    import carfield_periph_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumPorts      = NumPeriphPorts,
    parameter bit                   CanEnable     = 1'b1,
    parameter int unsigned          TimeoutCycles = 256,
    parameter logic [DataWidth-1:0] ErrData       = DataWidth'(ErrDataDefault)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          s_psel_i,
    input  logic                          s_penable_i,
    input  logic                          s_pwrite_i,
    input  logic [AddrWidth-1:0]          s_paddr_i,
    input  logic [DataWidth-1:0]          s_pwdata_i,
    input  logic [DataWidth/8-1:0]        s_pstrb_i,
    input  logic [2:0]                    s_pprot_i,
    output logic                          s_pready_o,
    output logic [DataWidth-1:0]          s_prdata_o,
    output logic                          s_pslverr_o,
    output logic [NumPorts-1:0]           m_psel_o,
    output logic                          m_penable_o,
    output logic                          m_pwrite_o,
    output logic [AddrWidth-1:0]          m_paddr_o,
    output logic [DataWidth-1:0]          m_pwdata_o,
    output logic [DataWidth/8-1:0]        m_pstrb_o,
    output logic [2:0]                    m_pprot_o,
    input  logic [NumPorts-1:0]           m_pready_i,
    input  logic [NumPorts-1:0]           m_pslverr_i,
    input  logic [NumPorts*DataWidth-1:0] m_prdata_i,
    output logic                          timeout_o,
    output logic [2:0]                    timeout_port_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntW      = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

    xbar_state_e           state_q, state_d;
    logic [PortIdxW-1:0]   port_q, port_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic [StrbWidth-1:0]  strb_q, strb_d;
    logic [2:0]            prot_q, prot_d;
    logic                  write_q, write_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [2:0]            tport_q, tport_d;
    logic                  timeout;

    logic [PortIdxW-1:0]   dec_idx;
    logic                  dec_hit;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DataWidth-1:0]  sel_rdata;

    carfield_periph_addr_decode #(
        .AddrWidth (AddrWidth),
        .NumRules  (NumPeriphPorts),
        .CanEnable (CanEnable)
    ) i_decode (
        .addr_i  (s_paddr_i),
        .rules_i (DefaultAddrMap),
        .idx_o   (dec_idx),
        .hit_o   (dec_hit)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (port_q == PortIdxW'(p)) begin
                sel_ready = m_pready_i[p];
                sel_err   = m_pslverr_i[p];
                sel_rdata = m_prdata_i[p*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tport_d = tport_q;
        timeout = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (s_psel_i && s_penable_i) begin
                    addr_d  = s_paddr_i;
                    prot_d  = s_pprot_i;
                    write_d = s_pwrite_i;
                    port_d  = dec_idx;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (dec_hit) begin
                        wdata_d = s_pwdata_i;
                        strb_d  = s_pstrb_i;
                        state_d = StSetup;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ErrData;
                        state_d = StResp;
                    end
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // A ready in the expiry cycle still wins over the abort.
                if (sel_ready) begin
                    rdata_d = write_q ? '0 : sel_rdata;
                    err_d   = sel_err;
                    state_d = StResp;
                end else if (cnt_q == CntMax) begin
                    timeout = 1'b1;
                    tport_d = port_q;
                    err_d   = 1'b1;
                    rdata_d = ErrData;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            port_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tport_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tport_q <= tport_d;
        end
    end

    always_comb begin
        m_psel_o = '0;
        if (state_q == StSetup || state_q == StAccess) begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                m_psel_o[p] = (port_q == PortIdxW'(p));
            end
        end
    end

    assign m_penable_o    = (state_q == StAccess);
    assign m_pwrite_o     = write_q;
    assign m_paddr_o      = addr_q;
    assign m_pwdata_o     = wdata_q;
    assign m_pstrb_o      = strb_q;
    assign m_pprot_o      = prot_q;
    assign s_pready_o     = (state_q == StResp);
    assign s_pslverr_o    = (state_q == StResp) && err_q;
    assign s_prdata_o     = rdata_q;
    assign timeout_o      = timeout;
    assign timeout_port_o = tport_q;

endmodule

// File: tb/tb_carfield_periph_apb_xbar.sv
// Directed vector bench for the Carfield peripheral APB crossbar.
// Second instance covers the CAN-disabled map.
module tb_carfield_periph_apb_xbar;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         s_psel, s_penable, s_pwrite;
    logic [31:0]  s_paddr, s_pwdata;
    logic [3:0]   s_pstrb;
    logic [2:0]   s_pprot;
    logic         s_pready, s_pslverr;
    logic [31:0]  s_prdata;
    logic [4:0]   m_psel;
    logic         m_penable, m_pwrite;
    logic [31:0]  m_paddr, m_pwdata;
    logic [3:0]   m_pstrb;
    logic [2:0]   m_pprot;
    logic [4:0]   m_pready_i, m_pslverr_i;
    logic [159:0] m_prdata_i;
    logic         timeout;
    logic [2:0]   timeout_port;

    logic         b_psel, b_penable;
    logic         b_pready, b_pslverr;
    logic [31:0]  b_prdata;
    logic [4:0]   b_m_psel;
    logic         b_m_penable, b_m_pwrite;
    logic [31:0]  b_m_paddr, b_m_pwdata;
    logic [3:0]   b_m_pstrb;
    logic [2:0]   b_m_pprot;
    logic [4:0]   b_m_pready_i, b_m_pslverr_i;
    logic [159:0] b_m_prdata_i;
    logic         b_timeout;
    logic [2:0]   b_timeout_port;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carfield_periph_apb_xbar dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_psel_i(s_psel), .s_penable_i(s_penable), .s_pwrite_i(s_pwrite),
        .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_pprot_i(s_pprot), .s_pready_o(s_pready), .s_prdata_o(s_prdata),
        .s_pslverr_o(s_pslverr), .m_psel_o(m_psel), .m_penable_o(m_penable),
        .m_pwrite_o(m_pwrite), .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata),
        .m_pstrb_o(m_pstrb), .m_pprot_o(m_pprot), .m_pready_i(m_pready_i),
        .m_pslverr_i(m_pslverr_i), .m_prdata_i(m_prdata_i),
        .timeout_o(timeout), .timeout_port_o(timeout_port)
    );

    carfield_periph_apb_xbar #(.CanEnable(1'b0)) dut_nocan (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_psel_i(b_psel), .s_penable_i(b_penable), .s_pwrite_i(s_pwrite),
        .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_pprot_i(s_pprot), .s_pready_o(b_pready), .s_prdata_o(b_prdata),
        .s_pslverr_o(b_pslverr), .m_psel_o(b_m_psel), .m_penable_o(b_m_penable),
        .m_pwrite_o(b_m_pwrite), .m_paddr_o(b_m_paddr), .m_pwdata_o(b_m_pwdata),
        .m_pstrb_o(b_m_pstrb), .m_pprot_o(b_m_pprot), .m_pready_i(b_m_pready_i),
        .m_pslverr_i(b_m_pslverr_i), .m_prdata_i(b_m_prdata_i),
        .timeout_o(b_timeout), .timeout_port_o(b_timeout_port)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          port;
        int          wait_c;
        logic [31:0] crdata;
        logic        cerr;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_psel;
        int          exp_lat;
        int          exp_tmo;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drives one upstream access and plays the selected completer.
    task automatic run_vec(input string nm, input vec_t v);
        int k, acc, tk, tcnt, lat;
        logic got, wok;
        logic [4:0] seen, oh;
        logic [31:0] rd;
        logic er;
        oh = 5'd1 << v.port;
        for (int p = 0; p < 5; p++)
            m_prdata_i[p*32 +: 32] = (p == v.port) ? v.crdata : 32'hFFFF_FFFF;
        m_pslverr_i = v.cerr ? oh : 5'd0;
        m_pready_i  = 5'd0;
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = v.write;
        s_paddr = v.addr; s_pwdata = v.wdata; s_pstrb = v.strb; s_pprot = 3'b010;
        @(negedge clk);
        s_penable = 1'b1;
        k = 0; acc = 0; tk = -1; tcnt = 0; lat = -1;
        got = 1'b0; wok = 1'b1; seen = 5'd0; rd = '0; er = 1'b0;
        while (!got && k < 400) begin
            @(negedge clk);
            k++;
            if (m_penable) acc++;
            m_pready_i = (m_penable && acc > v.wait_c) ? m_psel : 5'd0;
            #1;
            seen |= m_psel;
            if (timeout) begin tcnt++; tk = k; end
            if (m_psel != 5'd0 &&
                (m_pwrite !== v.write || m_paddr !== v.addr ||
                 m_pwdata !== v.wdata || m_pstrb !== v.strb || m_pprot !== 3'b010))
                wok = 1'b0;
            if (s_pready) begin
                got = 1'b1; lat = k; rd = s_prdata; er = s_pslverr;
            end
        end
        s_psel = 1'b0; s_penable = 1'b0; m_pready_i = 5'd0;
        chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_err"}, {31'd0, er}, {31'd0, v.exp_err});
        chk({nm, "_rdata"}, rd, v.exp_rdata);
        chk({nm, "_psel"}, {27'd0, seen}, {27'd0, v.exp_psel});
        chk({nm, "_tmo_cnt"}, 32'(tcnt), 32'(v.exp_tmo));
        if (v.exp_psel != 5'd0) chk({nm, "_fwd"}, {31'd0, wok}, 32'd1);
        if (v.exp_tmo != 0) begin
            chk({nm, "_tmo_cyc"}, 32'(tk), 32'(v.exp_lat - 1));
            chk({nm, "_tport"}, {29'd0, timeout_port}, 32'(v.port));
        end
        @(negedge clk);
        #1;
        chk({nm, "_pready_1cyc"}, {31'd0, s_pready}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stuck");
    end

    initial begin
        vt[0]  = '{1'b0, 32'h2000_4010, 32'h0, 4'h0, 1, 0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 5'b00010, 3, 0};
        vt[1]  = '{1'b1, 32'h2000_9000, 32'hA5A5_A5A5, 4'hF, 4, 4, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 5'b10000, 7, 0};
        vt[2]  = '{1'b0, 32'h2000_2000, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b1, 32'hBADC_AB1E, 5'b00000, 1, 0};
        vt[3]  = '{1'b0, 32'h2000_1FFC, 32'h0, 4'h0, 0, 1, 32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001, 5'b00001, 4, 0};
        vt[4]  = '{1'b0, 32'h2000_1000, 32'h0, 4'h0, 0, 0, 32'hC0DE_0000, 1'b0, 1'b0, 32'hC0DE_0000, 5'b00001, 3, 0};
        vt[5]  = '{1'b0, 32'h2000_5000, 32'h0, 4'h0, 2, 2, 32'h0BAD_0002, 1'b1, 1'b1, 32'h0BAD_0002, 5'b00100, 5, 0};
        vt[6]  = '{1'b0, 32'h2000_0FFC, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b1, 32'hBADC_AB1E, 5'b00000, 1, 0};
        vt[7]  = '{1'b0, 32'h2000_A000, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b1, 32'hBADC_AB1E, 5'b00000, 1, 0};
        vt[8]  = '{1'b0, 32'h2000_7FFC, 32'h0, 4'h0, 3, 0, 32'h7777_7777, 1'b0, 1'b0, 32'h7777_7777, 5'b01000, 3, 0};
        vt[9]  = '{1'b1, 32'h2000_6000, 32'h1111_2222, 4'h3, 0, 0, 32'h0, 1'b0, 1'b1, 32'hBADC_AB1E, 5'b00000, 1, 0};
        vt[10] = '{1'b0, 32'h2000_7000, 32'h0, 4'h0, 3, 1000, 32'h0, 1'b0, 1'b1, 32'hBADC_AB1E, 5'b01000, 258, 1};
        vt[11] = '{1'b0, 32'h2000_4000, 32'h0, 4'h0, 1, 255, 32'h5555_AAAA, 1'b0, 1'b0, 32'h5555_AAAA, 5'b00010, 258, 0};
        vt[12] = '{1'b1, 32'h2000_4FFC, 32'h0F0F_0F0F, 4'h5, 1, 0, 32'h9999_9999, 1'b0, 1'b0, 32'h0, 5'b00010, 3, 0};
        vt[13] = '{1'b0, 32'h2000_5000, 32'h0, 4'h0, 2, 0, 32'h5A5A_0000, 1'b0, 1'b0, 32'h5A5A_0000, 5'b00100, 3, 0};

        rst_ni = 1'b0;
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
        b_psel = 1'b0; b_penable = 1'b0;
        m_pready_i = '0; m_pslverr_i = '0; m_prdata_i = '0;
        b_m_pready_i = '0; b_m_pslverr_i = '0; b_m_prdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_psel", {27'd0, m_psel}, 32'd0);
        chk("rst_penable", {31'd0, m_penable}, 32'd0);
        chk("rst_pready", {31'd0, s_pready}, 32'd0);
        chk("rst_pslverr", {31'd0, s_pslverr}, 32'd0);
        chk("rst_prdata", s_prdata, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_tport", {29'd0, timeout_port}, 32'd0);
        chk("rst_paddr", m_paddr, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vt[i]);

        // Hung watchdog, then a late ready must not produce a response.
        run_vec("wdog_tmo", vt[10]);
        m_pready_i = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("late_pready", {31'd0, s_pready}, 32'd0);
            chk("late_psel", {27'd0, m_psel}, 32'd0);
            chk("late_timeout", {31'd0, timeout}, 32'd0);
        end
        m_pready_i = 5'd0;
        run_vec("can_after_tmo", vt[3]);
        chk("tport_sticky", {29'd0, timeout_port}, 32'd3);

        // CAN window with the CAN rule removed.
        @(negedge clk);
        s_paddr = 32'h2000_1000; s_pwrite = 1'b0; b_psel = 1'b1; b_penable = 1'b0;
        @(negedge clk);
        b_penable = 1'b1;
        @(negedge clk);
        #1;
        chk("nocan_pready", {31'd0, b_pready}, 32'd1);
        chk("nocan_err", {31'd0, b_pslverr}, 32'd1);
        chk("nocan_rdata", b_prdata, 32'hBADC_AB1E);
        chk("nocan_psel", {27'd0, b_m_psel}, 32'd0);
        b_psel = 1'b0; b_penable = 1'b0;
        @(negedge clk);
        #1;
        chk("nocan_pready_1cyc", {31'd0, b_pready}, 32'd0);

        // Reset in the middle of an ACCESS phase.
        m_pready_i = 5'd0;
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = 32'h2000_5000; s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
        @(negedge clk);
        s_penable = 1'b1;
        for (int k = 0; k < 10 && !m_penable; k++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_mid_in_access", {31'd0, m_penable}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_psel", {27'd0, m_psel}, 32'd0);
        chk("rst_mid_penable", {31'd0, m_penable}, 32'd0);
        chk("rst_mid_pready", {31'd0, s_pready}, 32'd0);
        chk("rst_mid_prdata", s_prdata, 32'd0);
        chk("rst_mid_tport", {29'd0, timeout_port}, 32'd0);
        chk("rst_mid_paddr", m_paddr, 32'd0);
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        run_vec("post_rst", vt[13]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
